// File: rtl/trigger_logic.sv
// trigger_logic: hysteresis level/edge trigger qualification, auto-trigger timeout and a
// synchronised external trigger path, gated by the capture controller's 'armed' handshake.
module trigger_logic #(
   parameter int unsigned HYST         = 2,
   parameter int unsigned AUTO_TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample_en,
   input  logic [7:0] ch1_data,
   input  logic [7:0] ch2_data,
   input  logic [7:0] ch3_data,
   input  logic       ext_trig,
   input  logic [7:0] trig_lvl,
   input  logic [4:0] trig_cfg,
   input  logic       armed,
   output logic       trigger,
   output logic       auto_fired,
   output logic [1:0] trig_state
);
   typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, WAIT = 2'd2, FIRED = 2'd3} state_t;

   localparam logic [8:0]  HYST_W    = 9'(HYST);
   localparam logic [16:0] TIMEOUT_W = 17'(AUTO_TIMEOUT);
   localparam logic [1:0]  MODE_OFF  = 2'b00;
   localparam logic [1:0]  MODE_AUTO = 2'b10;
   localparam logic [1:0]  MODE_EXT  = 2'b11;
   localparam logic [1:0]  SRC_NONE  = 2'b11;

   function automatic logic [7:0] sat_hi(input logic [7:0] lvl);
      logic [8:0] s;
      s = {1'b0, lvl} + HYST_W;
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   function automatic logic [7:0] sat_lo(input logic [7:0] lvl);
      logic [8:0] s;
      s = {1'b0, lvl} - HYST_W;
      return s[8] ? 8'h00 : s[7:0];
   endfunction

   state_t      state, state_nxt;
   logic        rising;
   logic [1:0]  mode, src;
   logic [7:0]  hi, lo, sample;
   logic        above;
   logic        ext_s1, ext_s2, ext_prev, ext_ev;
   logic [12:0] cfg_q;
   logic        cfg_vld, cfg_chg, enabled;
   logic        lvl_ev, ev, to_hit, fire, fire_auto;
   logic [15:0] cnt;

   assign rising     = trig_cfg[4];
   assign mode       = trig_cfg[3:2];
   assign src        = trig_cfg[1:0];
   assign hi         = sat_hi(trig_lvl);
   assign lo         = sat_lo(trig_lvl);
   assign trig_state = state;

   always_comb begin
      case (src)
         2'b00:   sample = ch1_data;
         2'b01:   sample = ch2_data;
         2'b10:   sample = ch3_data;
         default: sample = 8'h00;
      endcase
   end

   // cfg_vld keeps the first cycle after reset from looking like a config change
   assign cfg_chg = cfg_vld && (cfg_q != {trig_cfg, trig_lvl});
   assign enabled = (mode == MODE_EXT) || ((mode != MODE_OFF) && (src != SRC_NONE));
   assign lvl_ev  = sample_en && (rising ? (!above && (sample >= hi)) : (above && (sample <= lo)));
   assign ev      = (mode == MODE_EXT) ? ext_ev : lvl_ev;
   assign to_hit  = (mode == MODE_AUTO) && sample_en && !ev &&
                    (({1'b0, cnt} + 17'd1) >= TIMEOUT_W);

   always_comb begin
      state_nxt = state;
      fire      = 1'b0;
      fire_auto = 1'b0;
      unique case (state)
         IDLE: begin
            if (armed && enabled && !cfg_chg)
               state_nxt = (mode == MODE_EXT) ? WAIT : PRIME;
         end
         PRIME: begin
            if (cfg_chg || !armed || !enabled) state_nxt = IDLE;
            else if (sample_en)                state_nxt = WAIT;
         end
         WAIT: begin
            if (cfg_chg || !armed || !enabled) begin
               state_nxt = IDLE;
            end else if (ev) begin
               fire      = 1'b1;
               state_nxt = FIRED;
            end else if (to_hit) begin
               fire      = 1'b1;
               fire_auto = 1'b1;
               state_nxt = FIRED;
            end
         end
         FIRED: begin
            if (!armed) state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         trigger    <= 1'b0;
         auto_fired <= 1'b0;
         cfg_vld    <= 1'b0;
      end else begin
         state   <= state_nxt;
         trigger <= fire;
         cfg_vld <= 1'b1;
         if ((state == WAIT) && (state_nxt == WAIT)) begin
            if ((mode == MODE_AUTO) && sample_en && !ev) cnt <= cnt + 16'd1;
         end else begin
            cnt <= '0;
         end
         if (fire)                    auto_fired <= fire_auto;
         else if (state_nxt == IDLE)  auto_fired <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      cfg_q <= {trig_cfg, trig_lvl};
   end

   // two-flop synchroniser, then a registered edge so the event lands two cycles after capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ext_s1   <= 1'b0;
         ext_s2   <= 1'b0;
         ext_prev <= 1'b0;
         ext_ev   <= 1'b0;
      end else begin
         ext_s1   <= ext_trig;
         ext_s2   <= ext_s1;
         ext_prev <= ext_s2;
         ext_ev   <= rising ? (ext_s2 & ~ext_prev) : (~ext_s2 & ext_prev);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         above <= 1'b0;
      end else if (sample_en) begin
         if (state == PRIME)                 above <= (sample >= trig_lvl);
         else if (!above && (sample >= hi))  above <= 1'b1;
         else if (above && (sample <= lo))   above <= 1'b0;
      end
   end
endmodule
